// File: rtl/mpu_tx_pack.sv
// Packs rising-edge-strobed mpu words into wide beats and queues them in a FWFT FIFO toward the stream sink.
// Optional underrun counter is built only when MPU_TX_UNDERRUN_CNT_EN is defined.
module mpu_tx_pack #(
  parameter int FIFO_DEPTH  = 16,
  parameter int WRITE_WIDTH = 16,
  parameter int AXIS_WIDTH  = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_ena,
  input  logic [WRITE_WIDTH-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic                   overflow,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [AXIS_WIDTH-1:0]  m_axis_tdata,
  output logic [15:0]            underrun_cnt
);
  localparam int RATIO = AXIS_WIDTH / WRITE_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic                  r_wr_ena_d;
  logic [IDX_W-1:0]      r_idx;
  logic [AXIS_WIDTH-1:0] r_beat;
  logic                  r_overflow;
  logic [PTR_W:0]        r_wptr;
  logic [PTR_W:0]        r_rptr;
  logic [AXIS_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic                  w_edge;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic [AXIS_WIDTH-1:0] w_beat_next;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                    (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_edge   = wr_ena & ~r_wr_ena_d;
  assign w_accept = w_edge & ~w_full;
  assign w_last   = (r_idx == IDX_W'(RATIO - 1));
  // A flush pushes only if the beat holds at least one word, counting one accepted this cycle.
  assign w_push   = ~w_full & ((w_accept & w_last) |
                               (flush & ((r_idx != '0) | w_accept)));
  assign w_pop    = ~w_empty & m_axis_tready;

  always_comb begin
    w_beat_next = r_beat;
    if (w_accept) w_beat_next[r_idx*WRITE_WIDTH +: WRITE_WIDTH] = wr_data;
  end

  // The assembly register is cleared on every push, so unwritten slots are already zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ena_d <= 1'b0;
      r_idx      <= '0;
      r_beat     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ena_d <= wr_ena;
      if (w_push) begin
        r_idx  <= '0;
        r_beat <= '0;
      end else if (w_accept) begin
        r_idx  <= r_idx + 1'b1;
        r_beat <= w_beat_next;
      end
      if ((w_edge | flush) & w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= w_beat_next;
  end

  assign wr_ready      = ~w_full;
  assign overflow      = r_overflow;
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = w_empty ? '0 : r_mem[r_rptr[PTR_W-1:0]];

`ifdef MPU_TX_UNDERRUN_CNT_EN
  logic        r_armed;
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed        <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_pop) r_armed <= 1'b1;
      if (r_armed && m_axis_tready && w_empty && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`else
  assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mpu_tx_pack.sv
// Randomised and directed bench for mpu_tx_pack against a queue-based model of the packing/FIFO rules.
module tb_mpu_tx_pack;
  localparam int DEPTH = 16;
  localparam int WW    = 16;
  localparam int AW    = 128;
  localparam int RATIO = AW / WW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_ena = 1'b0;
  logic [WW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          flush = 1'b0;
  logic          overflow;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [AW-1:0] m_axis_tdata;
  logic [15:0]   underrun_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [AW-1:0] m_q[$];
  logic [WW-1:0] m_words[$];
  logic          m_ena_d = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_armed = 1'b0;
  int            m_under = 0;

  mpu_tx_pack #(.FIFO_DEPTH(DEPTH), .WRITE_WIDTH(WW), .AXIS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_data(wr_data), .wr_ready(wr_ready),
    .flush(flush), .overflow(overflow), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: words collect in a list, full or flushed lists become beats in a queue.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_q.delete(); m_words.delete();
      m_ena_d = 1'b0; m_ovf = 1'b0; m_armed = 1'b0; m_under = 0;
    end else begin
      automatic bit ready = (m_q.size() < DEPTH);
      automatic bit valid = (m_q.size() > 0);
      automatic bit edg   = wr_ena && !m_ena_d;
`ifdef MPU_TX_UNDERRUN_CNT_EN
      if (m_armed && m_axis_tready && !valid && m_under < 65535) m_under++;
      if (valid && m_axis_tready) m_armed = 1'b1;
`endif
      if ((edg || flush) && !ready) m_ovf = 1'b1;
      if (valid && m_axis_tready) void'(m_q.pop_front());
      if (edg && ready) m_words.push_back(wr_data);
      if (ready && (m_words.size() == RATIO || (flush && m_words.size() > 0))) begin
        automatic logic [AW-1:0] beat = '0;
        for (int i = 0; i < m_words.size(); i++) beat[i*WW +: WW] = m_words[i];
        m_q.push_back(beat);
        m_words.delete();
      end
      m_ena_d = wr_ena;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("cmp_tvalid", AW'(m_axis_tvalid), AW'(m_q.size() > 0));
      check("cmp_wr_ready", AW'(wr_ready), AW'(m_q.size() < DEPTH));
      check("cmp_overflow", AW'(overflow), AW'(m_ovf));
      check("cmp_underrun", AW'(underrun_cnt), AW'(m_under));
      if (m_q.size() > 0) check("cmp_tdata", m_axis_tdata, m_q[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_word(input logic [WW-1:0] d);
    wr_ena = 1'b1; wr_data = d;
    step();
    wr_ena = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    step();
    check("reset_tvalid", AW'(m_axis_tvalid), '0);
    check("reset_wr_ready", AW'(wr_ready), AW'(1));
    check("reset_overflow", AW'(overflow), '0);
    check("reset_tdata", m_axis_tdata, '0);
    check("reset_underrun", AW'(underrun_cnt), '0);
    step();
    rst = 1'b0;

    // eight words form one beat; tvalid one cycle after the last edge
    for (int i = 1; i <= 7; i++) wr_word(WW'(i));
    check("beat8_tvalid_before", AW'(m_axis_tvalid), '0);
    wr_ena = 1'b1; wr_data = 16'h0008;
    step();
    check("beat8_tvalid_after", AW'(m_axis_tvalid), AW'(1));
    check("beat8_tdata", m_axis_tdata, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    wr_ena = 1'b0;
    step();
    // pop the beat, then ten empty ready cycles
    m_axis_tready = 1'b1;
    step();
    check("pop_tvalid", AW'(m_axis_tvalid), '0);
    for (int i = 0; i < 10; i++) step();
`ifdef MPU_TX_UNDERRUN_CNT_EN
    check("underrun_10", AW'(underrun_cnt), AW'(10));
`else
    check("underrun_off", AW'(underrun_cnt), '0);
`endif
    m_axis_tready = 1'b0;

    // held strobe counts once
    wr_ena = 1'b1; wr_data = 16'h1111;
    for (int i = 0; i < 20; i++) step();
    wr_ena = 1'b0;
    step();
    for (int i = 2; i <= 8; i++) wr_word(WW'(16'h2200 + i));
    check("held_tvalid", AW'(m_axis_tvalid), AW'(1));
    check("held_tdata", m_axis_tdata, 128'h2208_2207_2206_2205_2204_2203_2202_1111);
    m_axis_tready = 1'b1; step(); m_axis_tready = 1'b0;

    // partial beat then flush
    wr_word(16'hAAAA); wr_word(16'hBBBB); wr_word(16'hCCCC);
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_tdata", m_axis_tdata, 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA);
    check("flush_idx_empty", AW'(m_words.size()), '0);
    m_axis_tready = 1'b1; step(); m_axis_tready = 1'b0;

    // fill to full, overflow on the extra edge, drain in order
    for (int i = 0; i < DEPTH * RATIO; i++) wr_word(WW'(i));
    check("full_wr_ready", AW'(wr_ready), '0);
    check("full_no_ovf", AW'(overflow), '0);
    wr_word(16'hDEAD);
    check("full_ovf", AW'(overflow), AW'(1));
    m_axis_tready = 1'b1;
    #1;
    check("full_ready_same_cycle", AW'(wr_ready), '0);
    check("full_head", m_axis_tdata, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    step();
    check("full_ready_next", AW'(wr_ready), AW'(1));
    for (int i = 0; i < DEPTH; i++) step();
    check("drained", AW'(m_axis_tvalid), '0);
    m_axis_tready = 1'b0;

    // reset mid-beat
    for (int i = 0; i < 5; i++) wr_word(16'h5500);
    do_reset();
    check("rst_tvalid", AW'(m_axis_tvalid), '0);
    check("rst_ovf", AW'(overflow), '0);
    for (int i = 0; i < RATIO; i++) wr_word(WW'(16'h7700 + i));
    check("rst_clean_beat", m_axis_tdata, 128'h7707_7706_7705_7704_7703_7702_7701_7700);
    m_axis_tready = 1'b1; step(); m_axis_tready = 1'b0;

    // random traffic, with phases of slow draining to reach full
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1) == 1) wr_ena = ~wr_ena;
      wr_data = WW'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      m_axis_tready = (i % 1000 < 500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1499) == 0) do_reset();
      step();
    end
    flush = 1'b0; wr_ena = 1'b0; m_axis_tready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mpu_tx_pack.md
MPU_TX_PACK -- requirements
Module: mpu_tx_pack

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: number of packed 128-bit entries; power of 2, minimum 4.
REQ-002 Parameter WRITE_WIDTH, default 16: microcontroller (EBI) word width.
REQ-003 Parameter AXIS_WIDTH, default 128: sample stream width; AXIS_WIDTH/WRITE_WIDTH (RATIO, default 8) is a power of 2.
REQ-004 clk  input  1  single clock; the mpu side and the stream side are both synchronous to it.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wr_ena  input  1  mpu write strobe, already synchronised to clk; only the rising edge is significant.
REQ-007 wr_data  input  WRITE_WIDTH  mpu write word, sampled on the wr_ena rising-edge cycle.
REQ-008 wr_ready  output  1  high when the FIFO can accept a completed beat.
REQ-009 flush  input  1  single-cycle pulse; zero-pads and pushes a partial beat.
REQ-010 overflow  output  1  sticky; a write edge or flush arrived while wr_ready=0.
REQ-011 m_axis_tvalid  output  1  stream data valid, toward the ad9361 TX path.
REQ-012 m_axis_tready  input  1  stream sink ready.
REQ-013 m_axis_tdata  output  AXIS_WIDTH  packed sample beat.
REQ-014 underrun_cnt  output  16  underrun counter (see Configuration).

Function
REQ-015 Edge detect: wr_ena_d <= wr_ena each cycle; accept = wr_ena & ~wr_ena_d & wr_ready.
REQ-016 A write edge with wr_ready=0 is dropped, does not advance the word index, and sets overflow.
REQ-017 Packing: word index idx (0..RATIO-1) places wr_data at bits [idx*WRITE_WIDTH +: WRITE_WIDTH]; the first word lands in the LSBs.
REQ-018 On accept with idx=RATIO-1, the assembled beat is written into the FIFO at that clock edge and idx wraps to 0.
REQ-019 Latency: m_axis_tvalid rises on the cycle after the edge that accepts the final word, if the FIFO was empty.
REQ-020 Flush with idx=0: no operation. With idx>0 and wr_ready=1: unwritten slots are zero, the beat is pushed, and idx returns to 0.
REQ-021 Flush and accept in the same cycle: the word is included first, then padding; if that word completes the beat, exactly one beat is pushed.
REQ-022 Flush with wr_ready=0 is ignored, sets overflow, and keeps the partial beat.
REQ-023 FIFO is first-word-fall-through: m_axis_tvalid = ~empty; m_axis_tdata = head entry; pop on m_axis_tvalid & m_axis_tready.
REQ-024 wr_ready = ~full, from registered occupancy. A pop in the same cycle does not raise wr_ready until the next cycle.
REQ-025 Push and pop in the same cycle leave occupancy unchanged. Pointers wrap modulo FIFO_DEPTH, with an extra MSB for full/empty.
REQ-026 m_axis_tdata holds stable while m_axis_tvalid=1 and m_axis_tready=0.

Reset
REQ-027 On rst: wr_ena_d, idx, pointers and overflow are cleared; underrun_cnt=0, m_axis_tvalid=0, wr_ready=1, m_axis_tdata=0.
REQ-028 Reset mid-beat discards the partial beat and all FIFO contents; the first edge after reset release is word 0.
REQ-029 After rst deasserts, the block accepts writes on the first clock; there is no busy period.

Configuration
REQ-030 Macro MPU_TX_UNDERRUN_CNT_EN is defined: underrun_cnt arms at the first pop, then counts (saturating at 16'hFFFF) each cycle with m_axis_tready=1 and m_axis_tvalid=0.
REQ-031 Macro not defined: underrun_cnt is constant 0, no counter logic is built, and the port remains present.

Verification
REQ-032 Eight edges with words 0x0001..0x0008 -> one beat 0x0008_0007_0006_0005_0004_0003_0002_0001; tvalid rises 1 cycle after the 8th edge.
REQ-033 wr_ena held high for 20 cycles -> exactly one word accepted.
REQ-034 Three words 0xAAAA,0xBBBB,0xCCCC then flush -> beat with 0xCCCC_BBBB_AAAA in the LSBs and zeros above; idx=0 afterward.
REQ-035 tready=0, write 16 beats (128 edges) -> wr_ready=0; 129th edge sets overflow; tready=1 -> 16 beats out in order; wr_ready rises the cycle after the first pop.
REQ-036 rst pulse after 5 words -> tvalid=0, overflow=0; the next 8 words form a clean beat.
REQ-037 MPU_TX_UNDERRUN_CNT_EN defined: one beat popped, then tready=1 for 10 empty cycles -> underrun_cnt=10. Macro not defined -> underrun_cnt=0.
